uart_rx_frame: RTL and testbench

//  Serial receive counterpart of uart_tx: samples the asynchronous rx line (8N1, LSB first), assembles

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_byte.sv | 115 +++++++++++
 rtl/uart_rx_frame.sv | 98 +++++++++
 tb/tb_uart_rx_frame.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  typedef logic [7:0] byte_t;

  // Clock cycles per bit; integer division truncates.
  function automatic int unsigned bit_cycles(input int unsigned clk_freq,
                                             input int unsigned baud);
    return clk_freq / baud;
  endfunction

  // Counter width able to hold 0 .. n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEF_BIT_CYC = bit_cycles(50_000_000, 115200);
  localparam int unsigned DEF_CNT_W   = cnt_width(DEF_BIT_CYC);

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: rx synchroniser, 8N1 byte FSM and bit timer.
// Emits a one-cycle byte_stb with a good byte or byte_err on a bad stop bit.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned boadrate = 115200
) (
  input  logic  clk,
  input  logic  arstn,
  input  logic  rx,
  output byte_t rx_byte,
  output logic  byte_stb,
  output logic  byte_err
);

  localparam int unsigned BIT_CYC = bit_cycles(CLK_FREQ, boadrate);
  localparam int unsigned HALF    = BIT_CYC / 2;
  localparam int unsigned CNT_W   = cnt_width(BIT_CYC);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BIT_CYC - 1);

  logic [1:0]       sync_q;
  logic             rx_d;
  logic             rx_s;
  logic             fall;

  rx_state_e        state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [2:0]       bit_q, bit_n;
  byte_t            sh_q, sh_n;

  assign rx_s    = sync_q[1];
  assign fall    = rx_d & ~rx_s;
  assign rx_byte = sh_q;

  // Two-flop synchroniser plus one delayed copy for edge detection; resets to idle-high.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      sync_q <= '1;
      rx_d   <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], rx};
      rx_d   <= sync_q[1];
    end
  end

  // FSM state, bit timer, bit index and shift register.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      bit_q   <= bit_n;
      sh_q    <= sh_n;
    end
  end

  // Next-state and strobe decode: mid-bit sampling, LSB first, one stop sample.
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    bit_n    = bit_q;
    sh_n     = sh_q;
    byte_stb = 1'b0;
    byte_err = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fall) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_n = '0;
          sh_n  = {rx_s, sh_q[7:1]};
          if (bit_q == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_n = bit_q + 1'b1;
          end
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_n    = '0;
          state_n  = IDLE;
          byte_stb = rx_s;
          byte_err = ~rx_s;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: collects DEPTH received bytes into one word, offered on valid/ready.
// Optional feature macro: UART_RX_ERR_EN adds the frame_err pulse output.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned boadrate = 115200,
  parameter int unsigned DEPTH    = 8
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  rx,
  output logic [DEPTH-1:0][7:0] data_o,
  output logic                  down_valid,
  input  logic                  down_ready
`ifdef UART_RX_ERR_EN
  ,
  output logic                  frame_err
`endif
);

  localparam int unsigned      IDX_W    = cnt_width(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  byte_t                  rx_byte;
  logic                   byte_stb;
  logic                   byte_err;
  logic [IDX_W-1:0]       idx_q;
  logic [DEPTH-1:0][7:0]  asm_q;
  logic [DEPTH-1:0][7:0]  word_n;
  logic                   word_done;
  logic                   handshake;
  logic                   take;

  uart_rx_byte #(
    .CLK_FREQ (CLK_FREQ),
    .boadrate (boadrate)
  ) u_byte (
    .clk      (clk),
    .arstn    (arstn),
    .rx       (rx),
    .rx_byte  (rx_byte),
    .byte_stb (byte_stb),
    .byte_err (byte_err)
  );

  // Assembly view with the incoming byte merged at its slot; also the completed word.
  always_comb begin
    word_n        = asm_q;
    word_n[idx_q] = rx_byte;
  end

  assign handshake = down_valid & down_ready;
  assign word_done = byte_stb & (idx_q == LAST_IDX);
  // A finished word is accepted if the output is free or being drained this cycle.
  assign take      = word_done & (~down_valid | down_ready);

  // Byte slot counter and assembly buffer; a framing error restarts the word.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      idx_q <= '0;
      asm_q <= '0;
    end else if (byte_err) begin
      idx_q <= '0;
    end else if (byte_stb) begin
      asm_q <= word_n;
      idx_q <= word_done ? '0 : idx_q + 1'b1;
    end
  end

  // Output word register and valid flag; an overrunning word is simply not loaded.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      data_o     <= '0;
      down_valid <= 1'b0;
    end else if (take) begin
      data_o     <= word_n;
      down_valid <= 1'b1;
    end else if (handshake) begin
      down_valid <= 1'b0;
    end
  end

`ifdef UART_RX_ERR_EN
  logic overrun;
  assign overrun = word_done & ~take;

  // One-cycle error pulse for framing errors and discarded words.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      frame_err <= 1'b0;
    end else begin
      frame_err <= byte_err | overrun;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame; runs with or without UART_RX_ERR_EN.
module tb_uart_rx_frame;

  localparam int unsigned CLK_FREQ = 50_000_000;
  localparam int unsigned BAUD     = 3_125_000;
  localparam int unsigned DEPTH    = 8;
  localparam int unsigned BC       = CLK_FREQ / BAUD;  // 16 cycles per bit

  logic                  clk = 1'b0;
  logic                  arstn = 1'b0;
  logic                  rx = 1'b1;
  logic [DEPTH-1:0][7:0] data_o;
  logic                  down_valid;
  logic                  down_ready = 1'b1;
`ifdef UART_RX_ERR_EN
  logic                  frame_err;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  logic [63:0] got_q[$];
  int unsigned err_cnt = 0;
  int unsigned stab_viol = 0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data = '0;
  int unsigned err_base;

  always #10 clk = ~clk;

  uart_rx_frame #(
    .CLK_FREQ (CLK_FREQ),
    .boadrate (BAUD),
    .DEPTH    (DEPTH)
  ) dut (
    .clk        (clk),
    .arstn      (arstn),
    .rx         (rx),
    .data_o     (data_o),
    .down_valid (down_valid),
    .down_ready (down_ready)
`ifdef UART_RX_ERR_EN
    ,
    .frame_err  (frame_err)
`endif
  );

  // Records accepted words, error pulses and any data change while stalled.
  always @(negedge clk) begin
    if (arstn && down_valid && down_ready) got_q.push_back(data_o);
    if (prev_stall && (data_o !== prev_data)) stab_viol++;
    prev_stall = arstn && down_valid && !down_ready;
    prev_data  = data_o;
`ifdef UART_RX_ERR_EN
    if (frame_err === 1'b1) err_cnt++;
`endif
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (BC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BC) @(negedge clk);
    end
    rx = stop;
    repeat (BC) @(negedge clk);
    rx = 1'b1;
    repeat (BC) @(negedge clk);
  endtask

  task automatic send_word(input logic [63:0] w);
    for (int i = 0; i < 8; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  localparam logic [63:0] W1 = 64'h01020304_10203040;
  localparam logic [63:0] W2 = 64'h00000000_11121314;
  localparam logic [63:0] WA = 64'hA7A6A5A4_A3A2A1A0;
  localparam logic [63:0] WB = 64'hB7B6B5B4_B3B2B1B0;
  localparam logic [63:0] WD = 64'hD7D6D5D4_D3D2D1D0;

  initial begin
    // 1. reset
    repeat (3) @(negedge clk);
    chk("reset_valid", 64'(down_valid), 64'd0);
    chk("reset_data", data_o, 64'd0);
`ifdef UART_RX_ERR_EN
    chk("reset_err", 64'(frame_err), 64'd0);
`endif
    arstn = 1'b1;
    repeat (2 * BC) @(negedge clk);
    chk("idle_valid", 64'(down_valid), 64'd0);

    // 2. one word, consumer always ready
    send_word(W1);
    repeat (4) @(negedge clk);
    chk("w1_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) chk("w1_data", got_q[0], W1);
    chk("w1_valid_drop", 64'(down_valid), 64'd0);

    // 3. stalled consumer, overrun discards second word
    down_ready = 1'b0;
    err_base = err_cnt;
    send_word(W1);
    repeat (4) @(negedge clk);
    chk("hold_valid", 64'(down_valid), 64'd1);
    chk("hold_data", data_o, W1);
    send_word(W2);
    repeat (4) @(negedge clk);
    chk("ovr_valid", 64'(down_valid), 64'd1);
    chk("ovr_data", data_o, W1);
    chk("ovr_count", 64'(got_q.size()), 64'd1);
`ifdef UART_RX_ERR_EN
    chk("ovr_err", 64'(err_cnt - err_base), 64'd1);
`endif
    down_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("drain_count", 64'(got_q.size()), 64'd2);
    if (got_q.size() > 1) chk("drain_data", got_q[1], W1);
    chk("drain_valid", 64'(down_valid), 64'd0);
    chk("stall_stable", 64'(stab_viol), 64'd0);

    // 4. framing error mid word drops the partial word
    err_base = err_cnt;
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    send_byte(8'h77, 1'b1);
    send_byte(8'h88, 1'b0);
    send_word(WA);
    repeat (4) @(negedge clk);
    chk("ferr_count", 64'(got_q.size()), 64'd3);
    if (got_q.size() > 2) chk("ferr_data", got_q[2], WA);
`ifdef UART_RX_ERR_EN
    chk("ferr_err", 64'(err_cnt - err_base), 64'd1);
`endif

    // 5. short low glitch between bytes is ignored
    for (int i = 0; i < 3; i++) send_byte(WB[8*i +: 8], 1'b1);
    rx = 1'b0;
    repeat (BC / 4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BC) @(negedge clk);
    chk("glitch_valid", 64'(down_valid), 64'd0);
    for (int i = 3; i < 8; i++) send_byte(WB[8*i +: 8], 1'b1);
    repeat (4) @(negedge clk);
    chk("glitch_count", 64'(got_q.size()), 64'd4);
    if (got_q.size() > 3) chk("glitch_data", got_q[3], WB);

    // 6. reset in the middle of the fifth byte
    for (int i = 0; i < 4; i++) send_byte(8'hC0 + 8'(i), 1'b1);
    rx = 1'b0;
    repeat (BC) @(negedge clk);
    rx = 1'b1;
    repeat (BC) @(negedge clk);
    rx = 1'b0;
    repeat (BC) @(negedge clk);
    arstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_valid", 64'(down_valid), 64'd0);
    chk("mid_rst_data", data_o, 64'd0);
    rx = 1'b1;
    arstn = 1'b1;
    repeat (3 * BC) @(negedge clk);
    send_word(WD);
    repeat (4) @(negedge clk);
    chk("post_rst_count", 64'(got_q.size()), 64'd5);
    if (got_q.size() > 4) chk("post_rst_data", got_q[4], WD);
    chk("final_stable", 64'(stab_viol), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
